// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch sequencer.
package inst_fetch_ctrl_pkg;

  localparam int          IFC_CPU_WIDTH = 32;
  localparam logic [31:0] IFC_RESET_PC  = 32'h0000_0000;
  localparam int          IFC_FQ_DEPTH  = 2;
  localparam int          IFC_PC_STEP   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_fifo.sv
// fetch_fifo: registered skid queue holding {pc, inst} pairs between fetch and decode.
module fetch_fifo
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int WIDTH = 2 * IFC_CPU_WIDTH,
  parameter int DEPTH = IFC_FQ_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full queue is only accepted when the head leaves in the same cycle.
  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != DEPTH_C) | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, feeds instruction/PC pairs to decode, handles redirect/halt.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_CHK_EN.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int                   CPU_WIDTH = IFC_CPU_WIDTH,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(IFC_RESET_PC),
  parameter int                   FQ_DEPTH  = IFC_FQ_DEPTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 fetch_en,
  output logic [CPU_WIDTH-1:0] inst_addr,
  input  logic [CPU_WIDTH-1:0] inst,
  input  logic                 redirect_en,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  input  logic                 halt_req,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [CPU_WIDTH-1:0] id_inst,
  output logic [CPU_WIDTH-1:0] id_pc,
`ifdef IF_MISALIGN_CHK_EN
  output logic                 misalign_err,
  output logic [CPU_WIDTH-1:0] misalign_addr,
`endif
  output logic                 fetch_busy
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

  fetch_state_e           state_q, state_d;
  logic [CPU_WIDTH-1:0]   pc_q, pc_d;
  logic [CPU_WIDTH-1:0]   redirect_tgt;
  logic [2*CPU_WIDTH-1:0] fq_wdata, fq_rdata;
  logic [CW-1:0]          fq_count;
  logic                   fq_empty;
  logic                   push, pop, bad_tgt;

`ifdef IF_MISALIGN_CHK_EN
  logic                 misalign_err_q;
  logic [CPU_WIDTH-1:0] misalign_addr_q, misalign_addr_d;

  assign bad_tgt = redirect_en & (redirect_pc[1:0] != 2'b00);
`else
  logic unused_redirect_lsb;

  assign bad_tgt             = 1'b0;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

  assign redirect_tgt = {redirect_pc[CPU_WIDTH-1:2], 2'b00};

  // A redirect blocks both ends of the queue so a stale head is never consumed.
  assign pop  = id_valid & id_ready & ~redirect_en;
  assign push = (state_q == S_FETCH) & fetch_en & ~halt_req & ~redirect_en
              & ((fq_count < DEPTH_C) | pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_en) begin
      if (bad_tgt) begin
        state_d = S_HALT;
      end else begin
        state_d = fetch_en ? S_FETCH : S_IDLE;
        pc_d    = redirect_tgt;
      end
    end else begin
      case (state_q)
        S_IDLE:  if (fetch_en) state_d = S_FETCH;
        S_FETCH: begin
          if (halt_req)       state_d = S_HALT;
          else if (!fetch_en) state_d = S_IDLE;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
      if (push) pc_d = pc_q + CPU_WIDTH'(IFC_PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  assign misalign_addr_d = bad_tgt ? redirect_pc : misalign_addr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_err_q  <= bad_tgt;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign misalign_err  = misalign_err_q;
  assign misalign_addr = misalign_addr_q;
`endif

  assign fq_wdata = {pc_q, inst};

  fetch_fifo #(
    .WIDTH (2 * CPU_WIDTH),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_fifo (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .flush_i (redirect_en),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (fq_wdata),
    .rdata_o (fq_rdata),
    .count_o (fq_count),
    .empty_o (fq_empty)
  );

  assign inst_addr  = pc_q;
  assign id_valid   = ~fq_empty;
  assign id_pc      = fq_rdata[2*CPU_WIDTH-1:CPU_WIDTH];
  assign id_inst    = fq_rdata[CPU_WIDTH-1:0];
  assign fetch_busy = (state_q == S_FETCH);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl; memory returns word[k] = k + 0x100.
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_en;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        fetch_busy;
`ifdef IF_MISALIGN_CHK_EN
  logic        misalign_err;
  logic [31:0] misalign_addr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign inst = {2'b00, inst_addr[31:2]} + 32'h100;

  inst_fetch_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .fetch_en      (fetch_en),
    .inst_addr     (inst_addr),
    .inst          (inst),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_inst       (id_inst),
    .id_pc         (id_pc),
`ifdef IF_MISALIGN_CHK_EN
    .misalign_err  (misalign_err),
    .misalign_addr (misalign_addr),
`endif
    .fetch_busy    (fetch_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; fetch_en = 1'b0; id_ready = 1'b0;
    redirect_en = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    #3;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd0);

    fetch_en = 1'b1; id_ready = 1'b1;
    @(negedge clk); rstn = 1'b1;

    // Streaming start
    step();
    chk("s1_busy", {31'd0, fetch_busy}, 32'd1);
    chk("s1_addr", inst_addr, 32'h0);
    chk("s1_valid", {31'd0, id_valid}, 32'd0);
    step();
    chk("s2_valid", {31'd0, id_valid}, 32'd1);
    chk("s2_pc", id_pc, 32'h0);
    chk("s2_inst", id_inst, 32'h100);
    chk("s2_addr", inst_addr, 32'h4);
    step();
    chk("s3_pc", id_pc, 32'h4);
    chk("s3_inst", id_inst, 32'h101);
    chk("s3_addr", inst_addr, 32'h8);

    // Decode stall: queue fills, PC freezes, head holds
    id_ready = 1'b0;
    step();
    chk("st_pc", id_pc, 32'h4);
    chk("st_addr", inst_addr, 32'hC);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("st_hold_pc", id_pc, 32'h4);
      chk("st_hold_inst", id_inst, 32'h101);
      chk("st_hold_addr", inst_addr, 32'hC);
      chk("st_hold_valid", {31'd0, id_valid}, 32'd1);
    end
    id_ready = 1'b1;
    step();
    chk("rl_pc8", id_pc, 32'h8);
    chk("rl_addr", inst_addr, 32'h10);
    step();
    chk("rl_pcC", id_pc, 32'hC);
    chk("rl_addr2", inst_addr, 32'h14);

    // Redirect on a full queue
    redirect_en = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_en = 1'b0;
    chk("rd_valid", {31'd0, id_valid}, 32'd0);
    chk("rd_addr", inst_addr, 32'h40);
    step();
    chk("rd_new_valid", {31'd0, id_valid}, 32'd1);
    chk("rd_new_pc", id_pc, 32'h40);
    chk("rd_new_inst", id_inst, 32'h110);
    chk("rd_new_addr", inst_addr, 32'h44);

    // Halt with two queued entries: drain then stop
    id_ready = 1'b0;
    step();
    chk("h_fill_addr", inst_addr, 32'h48);
    halt_req = 1'b1; id_ready = 1'b1;
    step();
    halt_req = 1'b0;
    chk("h_busy", {31'd0, fetch_busy}, 32'd0);
    chk("h_pc44", id_pc, 32'h44);
    chk("h_valid", {31'd0, id_valid}, 32'd1);
    chk("h_addr", inst_addr, 32'h48);
    step();
    chk("h_drained", {31'd0, id_valid}, 32'd0);
    step();
    chk("h_stay_valid", {31'd0, id_valid}, 32'd0);
    chk("h_stay_addr", inst_addr, 32'h48);
    redirect_en = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_en = 1'b0;
    chk("h_res_addr", inst_addr, 32'h80);
    chk("h_res_busy", {31'd0, fetch_busy}, 32'd1);
    step();
    chk("h_res_pc", id_pc, 32'h80);
    chk("h_res_inst", id_inst, 32'h120);

    // Halt and redirect together with fetch disabled: redirect wins, go idle
    halt_req = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h100; fetch_en = 1'b0;
    step();
    halt_req = 1'b0; redirect_en = 1'b0;
    chk("hr_busy", {31'd0, fetch_busy}, 32'd0);
    chk("hr_addr", inst_addr, 32'h100);
    chk("hr_valid", {31'd0, id_valid}, 32'd0);
    step();
    chk("hr_idle_addr", inst_addr, 32'h100);

    // Misaligned redirect target
    fetch_en = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h203;
    step();
    redirect_en = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
    chk("ma_err", {31'd0, misalign_err}, 32'd1);
    chk("ma_addr", misalign_addr, 32'h203);
    chk("ma_pc", inst_addr, 32'h100);
    chk("ma_busy", {31'd0, fetch_busy}, 32'd0);
    step();
    chk("ma_err_pulse", {31'd0, misalign_err}, 32'd0);
    chk("ma_addr_hold", misalign_addr, 32'h203);
    chk("ma_valid", {31'd0, id_valid}, 32'd0);
    chk("ma_pc_hold", inst_addr, 32'h100);
`else
    chk("al_addr", inst_addr, 32'h200);
    chk("al_busy", {31'd0, fetch_busy}, 32'd1);
    step();
    chk("al_pc", id_pc, 32'h200);
    chk("al_inst", id_inst, 32'h180);
`endif

    // PC wrap at top of address space
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_en = 1'b0;
    chk("wr_addr", inst_addr, 32'hFFFF_FFFC);
    chk("wr_valid", {31'd0, id_valid}, 32'd0);
    step();
    chk("wr_pc", id_pc, 32'hFFFF_FFFC);
    chk("wr_inst", id_inst, 32'h4000_00FF);
    chk("wr_addr0", inst_addr, 32'h0);
    step();
    chk("wr_pc0", id_pc, 32'h0);
    chk("wr_inst0", id_inst, 32'h100);

    // Asynchronous reset mid-cycle while streaming
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_valid", {31'd0, id_valid}, 32'd0);
    chk("ar_addr", inst_addr, 32'h0);
    chk("ar_busy", {31'd0, fetch_busy}, 32'd0);
    chk("ar_pc", id_pc, 32'h0);
    chk("ar_inst", id_inst, 32'h0);
    @(negedge clk); rstn = 1'b1;
    step();
    chk("ar_s1_busy", {31'd0, fetch_busy}, 32'd1);
    chk("ar_s1_valid", {31'd0, id_valid}, 32'd0);
    step();
    chk("ar_s2_pc", id_pc, 32'h0);
    chk("ar_s2_inst", id_inst, 32'h100);

    // fetch_en drop returns to idle; head drains, no new fetch
    fetch_en = 1'b0;
    step();
    chk("fe_busy", {31'd0, fetch_busy}, 32'd0);
    chk("fe_valid", {31'd0, id_valid}, 32'd0);
    chk("fe_addr", inst_addr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Fetch sequencer for the combinational instruction memory in the five-stage pipeline. Owns the PC and drives the instruction memory address every cycle. Captures each returned instruction with its PC into a small skid FIFO. Hands instruction/PC pairs to decode over a valid/ready handshake, and handles redirects from branches and jumps, stalls and halt.

Parameters:
- CPU_WIDTH, 32, datapath/address width (matches the `CPU_WIDTH` define).
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FQ_DEPTH, 2, fetch-queue entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- fetch_en  in  1  global run enable; 0 = no new fetches.
- inst_addr  out  CPU_WIDTH  byte address to instruction memory (= pc_q).
- inst  in  CPU_WIDTH  instruction word, combinationally valid for inst_addr in the same cycle.
- redirect_en  in  1  branch/jump taken; 1-cycle pulse from EX.
- redirect_pc  in  CPU_WIDTH  redirect target.
- halt_req  in  1  stop fetching (ebreak/ecall path).
- id_valid  out  1  queue head valid.
- id_ready  in  1  decode accepts head.
- id_inst  out  CPU_WIDTH  head instruction.
- id_pc  out  CPU_WIDTH  head PC.
- fetch_busy  out  1  state == S_FETCH.

Behaviour:
- Reset (async, rstn=0): pc_q=RESET_PC; queue empty (count=0, rd/wr ptr=0); id_valid=0; id_inst=0; id_pc=0; state=S_IDLE; fetch_busy=0. Reset mid-stream discards all queue contents immediately.
- inst_addr = pc_q at all times, including IDLE and HALT.
- FSM:
  - S_IDLE: leaves to S_FETCH on fetch_en=1.
  - S_FETCH: enters S_HALT on halt_req; returns to S_IDLE on fetch_en=0.
  - S_HALT: leaves only on redirect_en, going to S_FETCH if fetch_en=1, else S_IDLE.
- pop = id_valid & id_ready & ~redirect_en.
- push = (state==S_FETCH) & fetch_en & ~halt_req & ~redirect_en & (count<FQ_DEPTH | pop).
- On push: entry{pc_q, inst} is written at wr_ptr and pc_q <= pc_q+4. Addition wraps modulo 2^CPU_WIDTH (32'hFFFF_FFFC+4 -> 0).
- Full queue with no pop: no push, and pc_q holds.
- Simultaneous push and pop on a full queue is legal; count stays unchanged.
- Latency: the first instruction appears on id_* the cycle after the first push (registered queue, 1-cycle fetch-to-decode). At steady state with id_ready=1, throughput is 1 instruction per cycle.
- Redirect (highest priority, any state):
  - queue flushed (count=0, ptrs=0) and pc_q <= redirect_pc;
  - no push and no pop that cycle;
  - id_valid goes 0 the next cycle;
  - an instruction presented with redirect_en=1 is never consumed.
- halt_req and redirect_en in the same cycle: redirect wins, and state goes to S_FETCH/S_IDLE per fetch_en.
- id_valid = (count!=0). id_inst/id_pc show the head entry, and hold stable while id_valid & ~id_ready.
- Queue pointers wrap modulo FQ_DEPTH.
- halt_req while the queue is non-empty: queued entries still drain to decode; only new fetches stop.

Optional Feature:
- Macro: IF_MISALIGN_CHK_EN.
- Defined:
  - adds outputs misalign_err (1) and misalign_addr (CPU_WIDTH), both reset to 0.
  - When redirect_en=1 with redirect_pc[1:0]!=2'b00: pc_q is not updated; the queue is flushed; misalign_err pulses for 1 cycle; misalign_addr latches redirect_pc; state goes to S_HALT.
- Undefined:
  - ports absent;
  - redirect_pc[1:0] is ignored (pc_q <= {redirect_pc[CPU_WIDTH-1:2],2'b00}).

Decomposition:
- Shared package/define file: CPU_WIDTH, RESET_PC default, and FSM state encodings (S_IDLE=2'd0, S_FETCH=2'd1, S_HALT=2'd2).
- One natural sub-module: fetch_fifo. It is a synchronous FIFO of width 2*CPU_WIDTH, depth FQ_DEPTH, with a flush input. The FSM and PC logic stay in inst_fetch_ctrl.

Test Plan:
- Reset then fetch_en=1, id_ready=1, memory preloaded with word[k]=k+0x100:
  - cycle 1: inst_addr=0x0;
  - cycle 2: id_valid=1, id_pc=0x0, id_inst=0x100;
  - continuing: one instruction per cycle, PCs 0x4, 0x8, ...
- id_ready=0 for 5 cycles:
  - queue fills to 2 entries and pc_q freezes at 0x8;
  - id_pc holds 0x0;
  - on release, PCs 0x0, 0x4, 0x8 are delivered in order with no gaps or duplicates.
- redirect_en pulse with redirect_pc=0x40 while the queue is full:
  - next cycle id_valid=0 and inst_addr=0x40;
  - the following cycle id_pc=0x40;
  - old entries are never accepted.
- halt_req at pc 0x10 with 2 queued entries:
  - both queued entries drain, then id_valid=0 and state=S_HALT;
  - redirect to 0x80 resumes fetch at 0x80.
- rstn asserted asynchronously mid-cycle during streaming: id_valid=0 and inst_addr=RESET_PC immediately, without waiting for a clock edge.
- With IF_MISALIGN_CHK_EN defined, redirect_pc=0x42:
  - misalign_err=1 for exactly 1 cycle and misalign_addr=0x42;
  - pc_q is unchanged and state=S_HALT.
